pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives per-stage register write enables, flushes and the ID/EX bubble; the bubble signal doubles as the control unit's hazard input.
- Detects load-use hazards in ID and resolves taken branches in MEM.
- Freezes the pipeline on data-memory wait. Inserts fetch bubbles on instruction-memory wait and discards wrong-path fetches still in flight at redirect.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control slice.
// Opcode encodings, hazard sequencer states and register constants.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b000001;
    localparam logic [5:0] OP_SW    = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000011;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        IMEM_WAIT = 2'd2
    } haz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use, taken branch, IMEM/DMEM wait handling.
// HAZ_PERF_CNT_EN enables the stall_cnt/flush_cnt performance counters.
import pipe_pkg::*;

module pipe_hazard_ctrl #(
    parameter int CNT_W      = 16,
    parameter int WDOG_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err_timeout
);

    localparam int WDOG_W = (WDOG_LIMIT > 2) ? $clog2(WDOG_LIMIT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX =
        WDOG_W'((WDOG_LIMIT > 0) ? WDOG_LIMIT - 1 : 0);

    haz_state_t        state_q;
    haz_state_t        state_d;
    logic              kill_pending;
    logic              kill_d;
    logic              dwait;
    logic              rt_reader;
    logic              load_use;
    logic              kill_now;
    logic [WDOG_W-1:0] wdog_q;

    // Once in DMEM_WAIT the access is held until ready even if req drops.
    assign dwait = (dmem_req || (state_q == DMEM_WAIT)) && !dmem_ready;

    assign rt_reader = (id_opcode == OP_RTYPE) ||
                       (id_opcode == OP_SW) ||
                       (id_opcode == OP_BEQ);

    assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) ||
                       (rt_reader && (ex_rt == id_rt)));

    assign kill_now = kill_pending && imem_ready;

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        state_d     = RUN;
        kill_d      = kill_pending;

        priority case (1'b1)
            reset: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_we     = 1'b0;
                exmem_we    = 1'b0;
                memwb_we    = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
                kill_d      = 1'b0;
            end
            dwait: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idex_we  = 1'b0;
                exmem_we = 1'b0;
                memwb_we = 1'b0;
                state_d  = DMEM_WAIT;
            end
            branch_taken: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
                kill_d      = !imem_ready;
                state_d     = imem_ready ? RUN : IMEM_WAIT;
            end
            load_use: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                state_d     = imem_ready ? RUN : IMEM_WAIT;
            end
            !imem_ready: begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
                state_d    = IMEM_WAIT;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Drop the wrong-path fetch; PC already holds the branch target.
        if (!reset && !dwait && !branch_taken && kill_now) begin
            ifid_flush = 1'b1;
            pc_we      = 1'b0;
            kill_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            kill_pending <= 1'b0;
        end else begin
            state_q      <= state_d;
            kill_pending <= kill_d;
        end
    end

    sat_counter #(.W(WDOG_W)) u_wdog (
        .clk (clk),
        .inc (dwait),
        .clr (reset || !dwait),
        .q   (wdog_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err_timeout <= 1'b0;
        end else if ((WDOG_LIMIT != 0) && dwait && (wdog_q == WDOG_MAX)) begin
            err_timeout <= 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .inc (!pc_we),
        .clr (reset),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .inc (!dwait && branch_taken),
        .clr (reset),
        .q   (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Two instances: CNT_W=16/WDOG_LIMIT=4 and CNT_W=2/WDOG_LIMIT=0.
module tb_pipe_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        ex_memread, branch_taken, imem_ready;
    logic        dmem_req, dmem_ready;

    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic        ifid_flush, idex_bubble, exmem_flush, err_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    logic        b_pc_we, b_ifid_we, b_idex_we, b_exmem_we, b_memwb_we;
    logic        b_ifid_flush, b_idex_bubble, b_exmem_flush, b_err;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    logic [7:0]  ctrl;
    int          checks = 0;
    int          errors = 0;

    assign ctrl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                   ifid_flush, idex_bubble, exmem_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(16), .WDOG_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_we(pc_we), .ifid_we(ifid_we),
        .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_flush(exmem_flush), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .err_timeout(err_timeout)
    );

    pipe_hazard_ctrl #(.CNT_W(2), .WDOG_LIMIT(0)) dut2 (
        .clk(clk), .reset(reset), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_we(b_pc_we), .ifid_we(b_ifid_we),
        .idex_we(b_idex_we), .exmem_we(b_exmem_we),
        .memwb_we(b_memwb_we), .ifid_flush(b_ifid_flush),
        .idex_bubble(b_idex_bubble), .exmem_flush(b_exmem_flush),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt),
        .err_timeout(b_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_opcode    = 6'b000000;
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        ex_memread   = 1'b0;
        ex_rt        = 5'd0;
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        dmem_req     = 1'b0;
        dmem_ready   = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle();
        #1;
        checks++;
        if (ctrl !== 8'b00000111) begin
            errors++;
            $display("FAIL reset_ctrl got %b want %b", ctrl, 8'b00000111);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got %0d/%0d/%b want 0/0/0",
                     stall_cnt, flush_cnt, err_timeout);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_load_use;
        do_reset();
        ex_memread = 1'b1;
        ex_rt      = 5'd5;
        id_opcode  = 6'b000000;
        id_rs      = 5'd5;
        #1;
        checks++;
        if (ctrl !== 8'b00111010) begin
            errors++;
            $display("FAIL load_use got %b want %b", ctrl, 8'b00111010);
        end
        tick();
        ex_memread = 1'b0;
        #1;
        checks++;
        if (ctrl !== 8'b11111000) begin
            errors++;
            $display("FAIL load_use_after got %b want %b", ctrl, 8'b11111000);
        end
        tick();
    endtask

    task automatic test_no_stall;
        ex_memread = 1'b1;
        ex_rt      = 5'd0;
        id_rs      = 5'd0;
        id_rt      = 5'd0;
        id_opcode  = 6'b000000;
        #1;
        checks++;
        if (ctrl !== 8'b11111000) begin
            errors++;
            $display("FAIL r0_no_stall got %b want %b", ctrl, 8'b11111000);
        end
        ex_rt     = 5'd7;
        id_rt     = 5'd7;
        id_rs     = 5'd3;
        id_opcode = 6'b000001;
        #1;
        checks++;
        if (ctrl !== 8'b11111000) begin
            errors++;
            $display("FAIL lw_rt_no_stall got %b want %b", ctrl, 8'b11111000);
        end
        id_opcode = 6'b000010;
        #1;
        checks++;
        if (ctrl !== 8'b00111010) begin
            errors++;
            $display("FAIL sw_rt_stall got %b want %b", ctrl, 8'b00111010);
        end
        id_opcode = 6'b000011;
        #1;
        checks++;
        if (ctrl !== 8'b00111010) begin
            errors++;
            $display("FAIL beq_rt_stall got %b want %b", ctrl, 8'b00111010);
        end
        idle();
    endtask

    task automatic test_dmem_wait;
        dmem_req     = 1'b1;
        dmem_ready   = 1'b0;
        branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctrl !== 8'b00000000) begin
                errors++;
                $display("FAIL dmem_hold%0d got %b want %b", i, ctrl, 8'b00000000);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctrl !== 8'b11111111) begin
            errors++;
            $display("FAIL dmem_release got %b want %b", ctrl, 8'b11111111);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_cnt !== (PERF ? 16'd4 : 16'd0) ||
            flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL dmem_counters got %0d/%0d want %0d/%0d",
                     stall_cnt, flush_cnt, PERF ? 4 : 0, PERF ? 1 : 0);
        end
        dmem_req = 1'b1;
        repeat (3) tick();
        dmem_ready = 1'b1;
        tick();
        idle();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wdog_cleared got %b want 0", err_timeout);
        end
    endtask

    task automatic test_redirect;
        do_reset();
        branch_taken = 1'b1;
        imem_ready   = 1'b0;
        #1;
        checks++;
        if (ctrl !== 8'b11111111) begin
            errors++;
            $display("FAIL redirect got %b want %b", ctrl, 8'b11111111);
        end
        tick();
        branch_taken = 1'b0;
        #1;
        checks++;
        if (ctrl !== 8'b01111100) begin
            errors++;
            $display("FAIL imem_wait got %b want %b", ctrl, 8'b01111100);
        end
        tick();
        imem_ready = 1'b1;
        #1;
        checks++;
        if (ctrl !== 8'b01111100) begin
            errors++;
            $display("FAIL kill_return got %b want %b", ctrl, 8'b01111100);
        end
        tick();
        #1;
        checks++;
        if (ctrl !== 8'b11111000) begin
            errors++;
            $display("FAIL after_kill got %b want %b", ctrl, 8'b11111000);
        end
        tick();
        checks++;
        if (stall_cnt !== (PERF ? 16'd2 : 16'd0) ||
            flush_cnt !== (PERF ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL redirect_counters got %0d/%0d want %0d/%0d",
                     stall_cnt, flush_cnt, PERF ? 2 : 0, PERF ? 1 : 0);
        end
    endtask

    task automatic test_watchdog;
        do_reset();
        dmem_req   = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (err_timeout !== (i == 4)) begin
                errors++;
                $display("FAIL wdog_cycle%0d got %b want %b",
                         i, err_timeout, (i == 4));
            end
        end
        dmem_ready = 1'b1;
        tick();
        idle();
        tick();
        checks++;
        if (err_timeout !== 1'b1 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_sticky got %b/%b want 1/0", err_timeout, b_err);
        end
        do_reset();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wdog_reset got %b want 0", err_timeout);
        end
    endtask

    task automatic test_saturate;
        do_reset();
        imem_ready = 1'b0;
        repeat (5) tick();
        idle();
        tick();
        tick();
        checks++;
        if (b_stall_cnt !== (PERF ? 2'd3 : 2'd0) ||
            stall_cnt !== (PERF ? 16'd5 : 16'd0)) begin
            errors++;
            $display("FAIL stall_saturate got %0d/%0d want %0d/%0d",
                     b_stall_cnt, stall_cnt, PERF ? 3 : 0, PERF ? 5 : 0);
        end
    endtask

    task automatic test_reset_mid_wait;
        idle();
        branch_taken = 1'b1;
        tick();
        dmem_req   = 1'b1;
        dmem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (ctrl !== 8'b00000111) begin
            errors++;
            $display("FAIL reset_in_wait got %b want %b", ctrl, 8'b00000111);
        end
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (ctrl !== 8'b11111000 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL after_reset_wait got %b/%0d/%0d want %b/0/0",
                     ctrl, stall_cnt, flush_cnt, 8'b11111000);
        end
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_no_stall();
        test_dmem_wait();
        test_redirect();
        test_watchdog();
        test_saturate();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
